// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared scalar types, reset PC and fetch-stage pipeline types.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  localparam u64 PCINIT = 64'h8000_0000;
endpackage

package pipes;
  import common::*;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} fetch_state_t;
  typedef struct packed {
    u32   raw_instr;
    u64   pc;
    logic valid;
  } fetch_data_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer with single-outstanding ibus request and redirect kill.
module fetch_ctrl
  import common::*;
  import pipes::*;
#(
  parameter u64 RESET_PC = PCINIT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output u64          ireq_addr,
  input  logic        iresp_data_ok,
  input  u32          iresp_data,
  input  logic        redirect_valid,
  input  u64          redirect_pc,
  input  logic        stall,
  output fetch_data_t dataF
);
  fetch_state_t state, n_state;
  u64 pc, n_pc, tgt, n_tgt, out_pc, n_out_pc, rt;
  u32 out_instr, n_out_instr;
  logic out_valid, n_out_valid;
  assign rt = redirect_pc & ~64'h3;
  assign ireq_valid = (state == REQ) || (state == KILL);
  assign ireq_addr = pc;
  assign dataF = {out_instr, out_pc, out_valid};
  always_comb begin
    n_state = state;
    n_pc = pc;
    n_tgt = tgt;
    n_out_instr = out_instr;
    n_out_pc = out_pc;
    n_out_valid = out_valid;
    case (state)
      IDLE: begin
        n_state = REQ;
        n_pc = redirect_valid ? rt : pc;
      end
      REQ: begin
        if (iresp_data_ok && !redirect_valid) begin
          n_out_instr = iresp_data;
          n_out_pc = pc;
          n_out_valid = 1'b1;
          n_pc = pc + 64'd4;
          n_state = HOLD;
        end else if (iresp_data_ok) begin
          n_pc = rt;
        end else if (redirect_valid) begin
          // the bus forbids withdrawing a request, so wait out the stale word
          n_tgt = rt;
          n_state = KILL;
        end
      end
      KILL: begin
        if (iresp_data_ok) begin
          n_pc = redirect_valid ? rt : tgt;
          n_state = REQ;
        end else if (redirect_valid) begin
          n_tgt = rt;
        end
      end
      default: begin
        if (redirect_valid || !stall) begin
          n_out_valid = 1'b0;
          n_pc = redirect_valid ? rt : pc;
          n_state = REQ;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      pc <= RESET_PC;
      tgt <= '0;
      out_instr <= '0;
      out_pc <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= n_state;
      pc <= n_pc;
      tgt <= n_tgt;
      out_instr <= n_out_instr;
      out_pc <= n_out_pc;
      out_valid <= n_out_valid;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;
  import common::*;
  import pipes::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ireq_valid;
  u64 ireq_addr;
  logic iresp_data_ok = 1'b0;
  u32 iresp_data = '0;
  logic redirect_valid = 1'b0;
  u64 redirect_pc = '0;
  logic stall = 1'b0;
  fetch_data_t dataF;
  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .dataF(dataF)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // one instruction with a 1-cycle memory: REQ, REQ+data_ok, HOLD, back to REQ
  task automatic fetch1(input logic [63:0] addr, input logic [31:0] instr);
    chk("req_valid", {63'd0, ireq_valid}, 64'd1);
    chk("req_addr", ireq_addr, addr);
    chk("req_dvalid", {63'd0, dataF.valid}, 64'd0);
    tick();
    chk("req2_addr", ireq_addr, addr);
    chk("req2_dvalid", {63'd0, dataF.valid}, 64'd0);
    iresp_data_ok = 1'b1;
    iresp_data = instr;
    tick();
    iresp_data_ok = 1'b0;
    chk("hold_dvalid", {63'd0, dataF.valid}, 64'd1);
    chk("hold_pc", dataF.pc, addr);
    chk("hold_instr", {32'd0, dataF.raw_instr}, {32'd0, instr});
    chk("hold_reqv", {63'd0, ireq_valid}, 64'd0);
    tick();
  endtask

  initial begin
    #3;
    chk("rst_reqv", {63'd0, ireq_valid}, 64'd0);
    chk("rst_dvalid", {63'd0, dataF.valid}, 64'd0);
    chk("rst_dpc", dataF.pc, 64'd0);
    chk("rst_instr", {32'd0, dataF.raw_instr}, 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    chk("idle_reqv", {63'd0, ireq_valid}, 64'd0);
    tick();
    fetch1(64'h8000_0000, 32'h1111_1111);
    fetch1(64'h8000_0004, 32'h2222_2222);
    fetch1(64'h8000_0008, 32'h3333_3333);
    // stalled HOLD
    chk("st_addr", ireq_addr, 64'h8000_000C);
    tick();
    iresp_data_ok = 1'b1;
    iresp_data = 32'hAAAA_5555;
    tick();
    iresp_data_ok = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("st_dvalid", {63'd0, dataF.valid}, 64'd1);
      chk("st_pc", dataF.pc, 64'h8000_000C);
      chk("st_instr", {32'd0, dataF.raw_instr}, 64'hAAAA_5555);
      chk("st_reqv", {63'd0, ireq_valid}, 64'd0);
      tick();
    end
    stall = 1'b0;
    chk("st_last_dvalid", {63'd0, dataF.valid}, 64'd1);
    tick();
    chk("resume_reqv", {63'd0, ireq_valid}, 64'd1);
    chk("resume_addr", ireq_addr, 64'h8000_0010);
    // redirect while waiting on a 3-cycle memory
    tick();
    redirect(64'h8000_1000);
    chk("kill_reqv", {63'd0, ireq_valid}, 64'd1);
    chk("kill_addr", ireq_addr, 64'h8000_0010);
    tick();
    chk("kill2_addr", ireq_addr, 64'h8000_0010);
    iresp_data_ok = 1'b1;
    iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 1'b0;
    chk("kill_drop_dvalid", {63'd0, dataF.valid}, 64'd0);
    chk("kill_new_addr", ireq_addr, 64'h8000_1000);
    chk("kill_new_reqv", {63'd0, ireq_valid}, 64'd1);
    // back-to-back redirects in KILL: latest wins
    redirect(64'h100);
    redirect(64'h200);
    chk("kk_addr", ireq_addr, 64'h8000_1000);
    iresp_data_ok = 1'b1;
    tick();
    iresp_data_ok = 1'b0;
    chk("kk_new_addr", ireq_addr, 64'h200);
    chk("kk_dvalid", {63'd0, dataF.valid}, 64'd0);
    // redirect together with data_ok in REQ, misaligned target
    iresp_data_ok = 1'b1;
    iresp_data = 32'h0BAD_0BAD;
    redirect(64'h8000_2002);
    iresp_data_ok = 1'b0;
    chk("same_reqv", {63'd0, ireq_valid}, 64'd1);
    chk("same_addr", ireq_addr, 64'h8000_2000);
    chk("same_dvalid", {63'd0, dataF.valid}, 64'd0);
    fetch1(64'h8000_2000, 32'h4444_4444);
    // redirect in KILL coinciding with data_ok
    redirect(64'h300);
    iresp_data_ok = 1'b1;
    redirect(64'h400);
    iresp_data_ok = 1'b0;
    chk("kok_addr", ireq_addr, 64'h400);
    // redirect beats stall in HOLD
    tick();
    iresp_data_ok = 1'b1;
    iresp_data = 32'h5555_5555;
    tick();
    iresp_data_ok = 1'b0;
    chk("hr_dvalid", {63'd0, dataF.valid}, 64'd1);
    chk("hr_pc", dataF.pc, 64'h400);
    stall = 1'b1;
    redirect(64'h500);
    stall = 1'b0;
    chk("hr_reqv", {63'd0, ireq_valid}, 64'd1);
    chk("hr_addr", ireq_addr, 64'h500);
    chk("hr_after_dvalid", {63'd0, dataF.valid}, 64'd0);
    // async reset in the middle of KILL
    redirect(64'h600);
    chk("mk_reqv", {63'd0, ireq_valid}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mk_rst_reqv", {63'd0, ireq_valid}, 64'd0);
    chk("mk_rst_dvalid", {63'd0, dataF.valid}, 64'd0);
    chk("mk_rst_addr", ireq_addr, 64'h8000_0000);
    tick();
    resetn = 1'b1;
    tick();
    fetch1(64'h8000_0000, 32'h6666_6666);
    // async reset during HOLD clears the output immediately; redirect in IDLE
    tick();
    iresp_data_ok = 1'b1;
    tick();
    iresp_data_ok = 1'b0;
    chk("mh_dvalid", {63'd0, dataF.valid}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mh_rst_dvalid", {63'd0, dataF.valid}, 64'd0);
    tick();
    resetn = 1'b1;
    redirect(64'h707);
    chk("idle_redir_addr", ireq_addr, 64'h704);
    chk("idle_redir_reqv", {63'd0, ireq_valid}, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the pipeline core. It owns the architectural fetch PC, drives a single-outstanding instruction-bus request, and absorbs redirects from later stages, including dropping a stale in-flight response. It also holds the fetched instruction in an output register until decode accepts it. It feeds `fetch_data_t` into the F/D pipeline register.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC fetched first after reset; bits [1:0] are zero.
- `clk`  in  1  single clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `ireq_valid`  out  1  instruction request valid; held until `iresp_data_ok`
- `ireq_addr`  out  64  request address; stable while `ireq_valid` is high
- `iresp_data_ok`  in  1  response strobe; one pulse per request
- `iresp_data`  in  32  instruction word; valid with `iresp_data_ok`
- `redirect_valid`  in  1  one-cycle pulse from execute/commit; flushes fetch
- `redirect_pc`  in  64  redirect target; bits [1:0] forced to 0 internally
- `stall`  in  1  decode not accepting `dataF` this cycle
- `dataF`  out  `fetch_data_t`  registered {raw_instr, pc, valid} to decode

## Operation
- The block has four states: IDLE, REQ, HOLD and KILL.
- Registers:
  - `pc` (64): current fetch PC.
  - `tgt` (64): pending redirect target.
  - `out_instr`, `out_pc`, `out_valid`: the output register driving `dataF`.
- Bus outputs:
  - `ireq_valid` = state is REQ or KILL.
  - `ireq_addr` = `pc`.
- IDLE:
  - Entered only from reset.
  - Next cycle goes to REQ.
  - A redirect in IDLE loads `pc` = target.
- REQ:
  - `data_ok` & !`redirect_valid`: `out_instr` = `iresp_data`, `out_pc` = `pc`, `out_valid` = 1, `pc` = `pc` + 4 (64-bit wrap), go to HOLD.
  - `data_ok` & `redirect_valid`: discard the word, `pc` = target, stay in REQ.
  - !`data_ok` & `redirect_valid`: `tgt` = target, go to KILL. The request must stay asserted because the bus forbids withdrawal.
- KILL:
  - The request stays on the bus at the old `pc`.
  - On `data_ok`: discard the word, `pc` = `tgt`, or the new target if `redirect_valid` is asserted in the same cycle; go to REQ.
  - Redirect without `data_ok`: `tgt` is overwritten (latest redirect wins).
- HOLD:
  - `ireq_valid` = 0; `out_valid` = 1.
  - `redirect_valid`: `out_valid` = 0, `pc` = target, go to REQ. Redirect has priority over `stall`.
  - Else !`stall`: `out_valid` = 0, go to REQ.
  - Else (stalled): hold everything.
- `dataF` = {`out_instr`, `out_pc`, `out_valid`}. When `out_valid` = 0, `raw_instr` and `pc` are don't-care.
- `out_valid` is asserted only in HOLD.

## Timing
- Reset values while `resetn` = 0 (asynchronous):
  - state = IDLE, `pc` = `RESET_PC`, `tgt` = 0.
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0.
  - Therefore `ireq_valid` = 0.
- After reset release:
  - Edge 1: IDLE→REQ.
  - `ireq_valid` = 1 from the cycle after edge 1, with `ireq_addr` = `RESET_PC`.
- Latency: a `data_ok` in cycle N gives `dataF.valid` = 1 in cycle N+1. The next request is asserted no earlier than cycle N+2.
- Peak throughput is one instruction per 2 cycles plus memory latency.
- `iresp_data_ok` outside REQ/KILL is ignored (bus protocol violation, not recovered).
- Reset asserted mid-transaction: immediate return to reset values. The instruction memory shares `resetn`, so no response is outstanding after reset.
- `redirect_valid` is sampled every cycle in every state. No redirect is ever lost.

## Structure
- `fetch_state_t` (2-bit enum IDLE/REQ/HOLD/KILL) goes in `pipes`.
- The default reset PC constant `PCINIT` goes in `common`, next to `u64`/`u32`.
- `fetch_data_t` is reused unchanged from `pipes`.
- One module, no sub-module. The next-PC adder and the next-state logic are an `always_comb` plus a single `always_ff` with asynchronous `negedge resetn`.

## Test plan
- Reset, then memory with a 1-cycle response, `stall` = 0:
  - `ireq_addr` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - `dataF.valid` pulses every 3rd cycle with matching `pc`/`raw_instr`.
- `stall` held for 4 cycles while in HOLD:
  - `dataF` stays constant and valid.
  - `ireq_valid` = 0 throughout.
  - Fetch resumes the cycle after `stall` drops.
- Redirect to 0x8000_1000 while a request waits (3-cycle memory):
  - The late response is discarded; no `dataF.valid` for it.
  - The next `ireq_addr` is 0x8000_1000.
- Redirect to 0x100 and then to 0x200 on consecutive KILL cycles before `data_ok`:
  - The next fetch is at 0x200.
- Redirect to 0x8000_2002 in the same cycle as `data_ok` in REQ:
  - The word is dropped.
  - `ireq_addr` = 0x8000_2000 with no HOLD cycle in between.
- Assert `resetn` = 0 mid-KILL:
  - `ireq_valid` and `dataF.valid` go to 0 immediately.
  - After release, the first fetch is at `RESET_PC`.
